// File: rtl/ika2151_pkg.sv
// ika2151_pkg: shared types and constants for the IKA2151 register-write path.
// States, write classes, address boundaries and the pending-write entry.
package ika2151_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PENDING,
      ST_HOLD
   } state_e;

   typedef enum logic [1:0] {
      WR_GLOBAL,
      WR_CHANNEL,
      WR_OPERATOR
   } wr_class_e;

   localparam logic [7:0] ADDR_CH_BASE = 8'h20;
   localparam logic [7:0] ADDR_OP_BASE = 8'h40;

   typedef struct packed {
      logic [7:0] addr;
      logic [7:0] data;
   } wr_entry_t;

endpackage

// File: rtl/ika2151_wr_slot_decode.sv
// ika2151_wr_slot_decode: register address to write class and slot target.
// Channel registers map to slots 0..7, operator registers to slots 0..31.
module ika2151_wr_slot_decode
   import ika2151_pkg::*;
(
   input  logic [7:0] addr,
   output wr_class_e  wr_class,
   output logic [4:0] target
);

   // Classify by address range; global writes carry no slot.
   always_comb begin
      wr_class = WR_GLOBAL;
      target   = 5'd0;
      if (addr < ADDR_CH_BASE) begin
         wr_class = WR_GLOBAL;
         target   = 5'd0;
      end else if (addr < ADDR_OP_BASE) begin
         wr_class = WR_CHANNEL;
         target   = {2'b00, addr[2:0]};
      end else begin
         wr_class = WR_OPERATOR;
         target   = addr[4:0];
      end
   end

endmodule

// File: rtl/ika2151_reg_write_sched.sv
// ika2151_reg_write_sched: schedules CPU writes onto the matching phi1 slot.
// Define IKA2151_WRITE_QUEUE_EN for a one-entry queue of writes made while busy.
module ika2151_reg_write_sched
   import ika2151_pkg::*;
#(
   parameter int BUSY_CYCLES = 32
)
(
   input  logic       i_EMUCLK,
   input  logic       i_RST,
   input  logic       i_phi1_NCEN_n,
   input  logic [4:0] i_CYCLE_NUM,
   input  logic       i_WR_STB,
   input  logic       i_A0,
   input  logic [7:0] i_DIN,
   output logic       o_BUSY,
   output logic       o_OVERRUN,
   output logic       o_REG_WE,
   output logic       o_GLOBAL_WE,
   output logic [7:0] o_REG_ADDR,
   output logic [7:0] o_REG_DATA
);

   localparam logic [5:0] BUSY_TH = 6'(BUSY_CYCLES);

   state_e     state;
   state_e     state_nxt;
   wr_entry_t  pend;
   wr_entry_t  stb_entry;
   logic [7:0] addr_latch;
   logic [5:0] busy_cnt;
   logic [5:0] cnt_inc;
   wr_class_e  pend_class;
   logic [4:0] pend_tgt;

   logic en;
   logic stb_addr;
   logic stb_data;
   logic busy;
   logic due;
   logic hold_done;
   logic accept;
   logic commit;
   logic from_q;
   logic overrun;

`ifdef IKA2151_WRITE_QUEUE_EN
   logic      q_valid;
   logic      q_push;
   wr_entry_t q_entry;
`endif

   assign en        = ~i_phi1_NCEN_n;
   assign stb_addr  = i_WR_STB & ~i_A0;
   assign stb_data  = i_WR_STB & i_A0;
   assign busy      = (state != ST_IDLE);
   assign o_BUSY    = busy;
   assign stb_entry = '{addr: addr_latch, data: i_DIN};
   assign cnt_inc   = (busy_cnt == 6'd63) ? busy_cnt : busy_cnt + 6'd1;
   assign hold_done = (cnt_inc >= BUSY_TH);
   assign due       = (pend_class == WR_GLOBAL) || (i_CYCLE_NUM == pend_tgt);

   ika2151_wr_slot_decode u_dec (
      .addr     (pend.addr),
      .wr_class (pend_class),
      .target   (pend_tgt)
   );

   // Next state, accept/commit/release decisions.
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      commit    = 1'b0;
      from_q    = 1'b0;
      unique case (state)
         ST_IDLE: begin
            if (stb_data) begin
               state_nxt = ST_PENDING;
               accept    = 1'b1;
            end
         end
         ST_PENDING: begin
            if (en && due) begin
               state_nxt = ST_HOLD;
               commit    = 1'b1;
            end
         end
         ST_HOLD: begin
            if (en && hold_done) begin
`ifdef IKA2151_WRITE_QUEUE_EN
               if (q_valid) begin
                  state_nxt = ST_PENDING;
                  from_q    = 1'b1;
               end else if (stb_data) begin
                  state_nxt = ST_PENDING;
                  accept    = 1'b1;
               end else begin
                  state_nxt = ST_IDLE;
               end
`else
               state_nxt = ST_IDLE;
`endif
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

`ifdef IKA2151_WRITE_QUEUE_EN
   assign q_push  = stb_data & busy & ~accept & (~q_valid | from_q);
   assign overrun = stb_data & busy & ~accept & ~q_push;

   // One-entry queue for a data write that lands while busy.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         q_valid <= 1'b0;
         q_entry <= '0;
      end else if (q_push) begin
         q_valid <= 1'b1;
         q_entry <= stb_entry;
      end else if (from_q) begin
         q_valid <= 1'b0;
      end
   end
`else
   assign overrun = stb_data & busy;
`endif

   // State register.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Address latch follows every address write, busy or not.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST)         addr_latch <= 8'h00;
      else if (stb_addr) addr_latch <= i_DIN;
   end

   // Pending entry captured on acceptance or taken from the queue.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         pend <= '0;
      end else if (accept) begin
         pend <= stb_entry;
`ifdef IKA2151_WRITE_QUEUE_EN
      end else if (from_q) begin
         pend <= q_entry;
`endif
      end
   end

   // Busy counter: restarts per write, counts enables while busy.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST)                busy_cnt <= 6'd0;
      else if (accept || from_q) busy_cnt <= 6'd0;
      else if (en && busy)      busy_cnt <= cnt_inc;
   end

   // Commit outputs: one-phi1 write strobes plus address/data.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) begin
         o_REG_WE    <= 1'b0;
         o_GLOBAL_WE <= 1'b0;
         o_REG_ADDR  <= 8'h00;
         o_REG_DATA  <= 8'h00;
      end else if (commit) begin
         o_REG_WE    <= (pend_class != WR_GLOBAL);
         o_GLOBAL_WE <= (pend_class == WR_GLOBAL);
         o_REG_ADDR  <= pend.addr;
         o_REG_DATA  <= pend.data;
      end else if (en) begin
         o_REG_WE    <= 1'b0;
         o_GLOBAL_WE <= 1'b0;
      end
   end

   // Overrun pulse for a discarded data write.
   always_ff @(posedge i_EMUCLK or posedge i_RST) begin
      if (i_RST) o_OVERRUN <= 1'b0;
      else       o_OVERRUN <= overrun;
   end

endmodule

// File: doc/ika2151_reg_write_sched.md
# ika2151_reg_write_sched

CPU register-write scheduler for the IKA2151 core. It latches the two-step address/data write from the bus interface and raises the busy flag. It then commits the write to the shared operator/channel register file only on the phi1 slot in which the timing-generator counter addresses the target slot. It sits between the bus interface and the register RAMs and uses the timing generator's phi1 negative-edge enable and 5-bit slot counter.

## Interface
Parameters:
- BUSY_CYCLES, 32: minimum number of phi1 enables o_BUSY stays high after a write is accepted (1..63)

Ports:
- i_EMUCLK  in  1  emulator master clock
- i_RST  in  1  reset; asynchronous and active-high
- i_phi1_NCEN_n  in  1  phi1 negative-edge clock enable, active low
- i_CYCLE_NUM  in  5  current slot-counter value (0..31)
- i_WR_STB  in  1  one-EMUCLK write strobe, already synchronized
- i_A0  in  1  0 = address write, 1 = data write
- i_DIN  in  8  bus data
- o_BUSY  out  1  write in progress
- o_OVERRUN  out  1  one-EMUCLK pulse when a data write is discarded
- o_REG_WE  out  1  slot register-file write enable
- o_GLOBAL_WE  out  1  global register (0x00–0x1F) write enable
- o_REG_ADDR  out  8  committed register address
- o_REG_DATA  out  8  committed register data

## Operation
- Address latch: i_WR_STB with i_A0=0 loads i_DIN. This is accepted in any state, including while busy, and never affects an already-accepted write.
- Data write: i_WR_STB with i_A0=1 in IDLE captures {address latch, i_DIN} into the pending entry and moves the block to PENDING.
- Target decode:
  - addr < 0x20: global write, no slot.
  - 0x20–0x3F: channel write, target = {2'b00, addr[2:0]}.
  - 0x40–0xFF: operator write, target = addr[4:0].
- FSM:
  - IDLE → PENDING on an accepted data write.
  - PENDING → HOLD on the first enable after acceptance where the write is due. A global write is due immediately. A slot write is due when i_CYCLE_NUM == target.
  - HOLD → IDLE on the enable where busy_cnt ≥ BUSY_CYCLES.
- Commit:
  - On the PENDING→HOLD enable, o_REG_ADDR and o_REG_DATA load the entry.
  - o_REG_WE (slot write) or o_GLOBAL_WE (global write) is set on that same enable and cleared on the next enable, so it lasts exactly one phi1 period.
- busy_cnt: a 6-bit counter, cleared on acceptance, incremented on each enable in PENDING or HOLD, saturating at 63.
- Busy flag: o_BUSY = (state ≠ IDLE). Because a slot target recurs within 32 enables, a commit is guaranteed by the 32nd enable.
- Data write while busy: discarded, and o_OVERRUN pulses for one EMUCLK. Behaviour with the queue compiled in is given under Configuration.

## Timing
- Reset values: all outputs 0, state IDLE, address latch 0x00, busy_cnt 0, queue empty.
- Reset mid-operation drops the pending write with no commit pulse.
- o_BUSY rises on the EMUCLK edge after the accepting strobe.
- If i_WR_STB and an enable coincide, that enable is not used for matching or counting.
- Commit latency:
  - Global write: 1 enable.
  - Slot write: 1..32 enables.
- o_BUSY falls on the EMUCLK edge after the releasing enable.
- If BUSY_CYCLES < the commit latency, release occurs on the enable after the commit.
- Counter wrap 31→0 needs no special handling; matching is equality only.

## Configuration
- IKA2151_WRITE_QUEUE_EN defined: a one-entry queue holds one data write that arrives while busy. That write still uses the address latch at strobe time.
  - On the releasing enable the queue entry moves directly into PENDING with busy_cnt cleared. o_BUSY stays high with no gap.
  - A data write arriving while busy with the queue full is discarded and pulses o_OVERRUN.
- Undefined: no queue; every data write while busy is discarded and pulses o_OVERRUN.

## Structure
- Package ika2151_pkg holds:
  - the state enum (IDLE/PENDING/HOLD);
  - the address boundary constants 0x20 and 0x40;
  - the write-class enum (GLOBAL/CHANNEL/OPERATOR).
- One sub-module, ika2151_wr_slot_decode: a combinational decode from address to {class, 5-bit target}, reused by the queue path.

## Test plan
- Global write: addr 0x18, data 0x5A, CYCLE_NUM = 7 → o_GLOBAL_WE for one phi1 at the first enable; o_REG_ADDR = 0x18, o_REG_DATA = 0x5A; o_BUSY high for exactly 32 enables.
- Operator write: addr 0x65 (target 5), accepted at CYCLE_NUM = 6 → o_REG_WE when CYCLE_NUM = 5, after 31 enables; o_BUSY falls on the 32nd enable.
- Channel write at wrap: addr 0x2B (target 3), accepted at CYCLE_NUM = 30 → commit at CYCLE_NUM = 3 after the 31→0 wrap.
- Overrun: second data write 10 EMUCLKs after the first →
  - without the macro: o_OVERRUN pulses and only the first write commits;
  - with the macro: both commit in order and o_BUSY never drops between them.
- Address rewrite while busy: write 0x40 = 0x11, then address 0x41 while busy → the commit shows o_REG_ADDR = 0x40; a later data write goes to 0x41.
- Reset mid-PENDING: assert i_RST with a slot write pending → all outputs 0 immediately and no o_REG_WE ever appears.
